counter_monitor: RTL and testbench

Passive checker that sits on the counter's output interface (clk, rst, mod, count) and consumes what the counter produces. It samples count each clock, predicts the next value from the current mode, and flags missing, repeated or out-of-order values. It also counts wrap-arounds and errors, and reports lock status. It is instantiated next to the counter in the block-level environment and in silicon as a built-in self-check.

---
 rtl/counter_monitor.sv | 116 +++++++++++
 tb/tb_counter_monitor.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
`default_nettype none
// ============================================================================
// counter_monitor : passive step checker for an up/down modulo-2^WIDTH counter
// Revision 1.0
// ============================================================================
module counter_monitor #(
   parameter int WIDTH  = 4,
   parameter int LOCK_N = 3,
   parameter int ECNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mod,
   input  logic [WIDTH-1:0]  count,
   output logic              locked,
   output logic              err,
   output logic              wrap,
   output logic [ECNT_W-1:0] err_cnt,
   output logic [ECNT_W-1:0] wrap_cnt
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] MAX_COUNT = '1;
   localparam logic [3:0]       LOCK_TGT  = 4'(LOCK_N);

   state_t           state, state_n;
   logic [WIDTH-1:0] prev_count;
   logic             prev_mod;
   logic             have_prev;
   logic [3:0]       run, run_n;
   logic             err_n, wrap_n;

   logic [WIDTH-1:0] exp_count;
   logic             mode_chg, correct, is_wrap;

   always_comb begin
      exp_count = prev_mod ? (prev_count + WIDTH'(1)) : (prev_count - WIDTH'(1));
      mode_chg  = have_prev && (mod != prev_mod);
      correct   = have_prev && !mode_chg && (count == exp_count);
      is_wrap   = prev_mod ? ((prev_count == MAX_COUNT) && (count == '0))
                           : ((prev_count == '0) && (count == MAX_COUNT));
   end

   always_comb begin
      state_n = state;
      run_n   = run;
      err_n   = 1'b0;
      wrap_n  = 1'b0;
      // The first sample after reset only primes prev_count/prev_mod.
      if (have_prev) begin
         case (state)
            UNLOCKED: begin
               if (correct) begin
                  run_n = run + 4'd1;
                  if (run_n >= LOCK_TGT) state_n = LOCKED;
               end else begin
                  run_n = 4'd0;
               end
            end
            LOCKED: begin
               if (mode_chg) begin
                  state_n = UNLOCKED;
                  run_n   = 4'd0;
               end else if (correct) begin
                  wrap_n = is_wrap;
               end else begin
                  state_n = FAULT;
                  run_n   = 4'd0;
                  err_n   = 1'b1;
               end
            end
            FAULT: begin
               state_n = UNLOCKED;
               run_n   = correct ? 4'd1 : 4'd0;
            end
            default: begin
               state_n = UNLOCKED;
               run_n   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= UNLOCKED;
         run        <= 4'd0;
         have_prev  <= 1'b0;
         prev_count <= '0;
         prev_mod   <= 1'b0;
         err        <= 1'b0;
         wrap       <= 1'b0;
         err_cnt    <= '0;
         wrap_cnt   <= '0;
      end else begin
         state      <= state_n;
         run        <= run_n;
         have_prev  <= 1'b1;
         prev_count <= count;
         prev_mod   <= mod;
         err        <= err_n;
         wrap       <= wrap_n;
         if (err_n && (err_cnt != '1))   err_cnt  <= err_cnt + ECNT_W'(1);
         if (wrap_n && (wrap_cnt != '1)) wrap_cnt <= wrap_cnt + ECNT_W'(1);
      end
   end

   assign locked = (state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// Bench for counter_monitor: directed steps queue their expected outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_counter_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       mod = 1'b0;
   logic [3:0] count = 4'd0;
   logic       locked, err, wrap;
   logic [7:0] err_cnt, wrap_cnt;

   counter_monitor #(.WIDTH(4), .LOCK_N(3), .ECNT_W(8)) dut (
      .clk(clk), .rst(rst), .mod(mod), .count(count),
      .locked(locked), .err(err), .wrap(wrap),
      .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       lk;
      logic       er;
      logic       wr;
      logic [7:0] ec;
      logic [7:0] wc;
   } exp_t;

   exp_t       q[$];
   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] e_err  = 8'd0;
   logic [7:0] e_wrap = 8'd0;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // One sample: drive inputs at the falling edge, queue what must follow the next rise.
   task automatic step(input logic r, input logic m, input logic [3:0] c,
                       input logic el, input logic ee, input logic ew);
      @(negedge clk);
      rst   = r;
      mod   = m;
      count = c;
      if (!r) begin
         e_err  = 8'd0;
         e_wrap = 8'd0;
      end
      if (ee && e_err != 8'hFF)  e_err++;
      if (ew && e_wrap != 8'hFF) e_wrap++;
      q.push_back('{lk: el, er: ee, wr: ew, ec: e_err, wc: e_wrap});
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("locked",   int'(locked),   int'(e.lk));
         chk("err",      int'(err),      int'(e.er));
         chk("wrap",     int'(wrap),     int'(e.wr));
         chk("err_cnt",  int'(err_cnt),  int'(e.ec));
         chk("wrap_cnt", int'(wrap_cnt), int'(e.wc));
      end
   end

   initial begin
      logic [3:0] v;

      // Held in reset with arbitrary inputs.
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);

      // Release and clean up-count: first edge primes, lock on the 4th edge.
      step(1, 1, 4'd0, 0, 0, 0);
      step(1, 1, 4'd1, 0, 0, 0);
      step(1, 1, 4'd2, 0, 0, 0);
      step(1, 1, 4'd3, 1, 0, 0);
      for (int i = 4; i <= 15; i++) step(1, 1, 4'(i), 1, 0, 0);

      // Up wrap 15 -> 0.
      step(1, 1, 4'd0, 1, 0, 1);
      for (int i = 1; i <= 6; i++) step(1, 1, 4'(i), 1, 0, 0);

      // Skipped value 7, then recovery.
      step(1, 1, 4'd8,  0, 1, 0);
      step(1, 1, 4'd9,  0, 0, 0);
      step(1, 1, 4'd10, 0, 0, 0);
      step(1, 1, 4'd11, 1, 0, 0);

      // Repeated value.
      step(1, 1, 4'd11, 0, 1, 0);
      step(1, 1, 4'd12, 0, 0, 0);
      step(1, 1, 4'd13, 0, 0, 0);
      step(1, 1, 4'd14, 1, 0, 0);

      // Legal direction change: lock drops without err, then re-acquires.
      step(1, 0, 4'd13, 0, 0, 0);
      step(1, 0, 4'd12, 0, 0, 0);
      step(1, 0, 4'd11, 0, 0, 0);
      step(1, 0, 4'd10, 1, 0, 0);

      // Down wrap 0 -> 15.
      for (int i = 9; i >= 0; i--) step(1, 0, 4'(i), 1, 0, 0);
      step(1, 0, 4'd15, 1, 0, 1);
      step(1, 0, 4'd14, 1, 0, 0);

      // Mode change together with a wrong value counts as a mode change only.
      step(1, 1, 4'd3, 0, 0, 0);
      step(1, 1, 4'd4, 0, 0, 0);
      step(1, 1, 4'd5, 0, 0, 0);
      step(1, 1, 4'd6, 1, 0, 0);

      // 300 errors, each followed by a re-lock; err_cnt must stick at 255.
      v = 4'd6;
      for (int i = 0; i < 300; i++) begin
         step(1, 1, v + 4'd2, 0, 1, 0);
         step(1, 1, v + 4'd3, 0, 0, 0);
         step(1, 1, v + 4'd4, 0, 0, 0);
         step(1, 1, v + 4'd5, 1, 0, 0);
         v = v + 4'd5;
      end

      // Asynchronous reset between clock edges.
      @(posedge clk);
      #3;
      rst    = 1'b0;
      e_err  = 8'd0;
      e_wrap = 8'd0;
      #1;
      chk("async_locked",   int'(locked),   0);
      chk("async_err",      int'(err),      0);
      chk("async_wrap",     int'(wrap),     0);
      chk("async_err_cnt",  int'(err_cnt),  0);
      chk("async_wrap_cnt", int'(wrap_cnt), 0);

      // Lock must be re-acquired from scratch.
      step(0, 1, 4'd9, 0, 0, 0);
      step(1, 1, 4'd5, 0, 0, 0);
      step(1, 1, 4'd6, 0, 0, 0);
      step(1, 1, 4'd7, 0, 0, 0);
      step(1, 1, 4'd8, 1, 0, 0);

      @(posedge clk);
      #2;
      chk("queue_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
